vx_elastic_arbiter: RTL and testbench
=====================================

Name: vx_elastic_arbiter

Overview:
- Round-robin arbiter that shares one elastic output channel among NUM_REQS valid/ready requesters.
- Supports multi-beat packets: a grant is held until the beat carrying last_in completes.
- Winning beats pass through an internal 2-entry skid stage, so the arbiter sustains full throughput and its ready paths are registered-friendly.
- Sits in front of shared memory/response queues wherever several producers feed one elastic buffer.

Parameters:
- NUM_REQS, 4, number of requesters (>=1)
- DATAW, 32, payload width per requester
- SEL_W, 2, sel_out width, = max(1, clog2(NUM_REQS))

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-low (0 = in reset)
- valid_in  input  NUM_REQS  per-requester valid
- ready_in  output  NUM_REQS  per-requester ready
- data_in  input  NUM_REQS*DATAW  packed payloads, requester i at [i*DATAW +: DATAW]
- last_in  input  NUM_REQS  final beat of packet
- valid_out  output  1  output valid
- ready_out  input  1  downstream ready
- data_out  output  DATAW  payload
- last_out  output  1  last flag of the output beat
- sel_out  output  SEL_W  index of the requester that produced the output beat
- locked  output  1  a packet is in progress (grant held)

Behaviour:
- Reset (reset=0, async): skid stage empty, valid_out=0, locked=0, lock index=0, round-robin pointer = NUM_REQS-1 (requester 0 has highest priority first). data_out, last_out and sel_out read 0.
- space = skid occupancy < 2. Occupancy is 0, 1 or 2; the head entry drives the outputs.
- Unlocked grant: first i with valid_in[i]=1, scanning from (ptr+1) mod NUM_REQS upward with wrap. Grant is combinational from registered state and valid_in.
- ready_in[i] = grant[i] & space. At most one bit set; ready_in is 0 for non-granted requesters.
- Transfer on requester i = valid_in[i] & ready_in[i]:
  - Beat {data, last, i} is pushed into the skid stage.
  - ptr <= i.
  - If last_in[i]=0: locked <= 1 and lock index <= i.
  - If last_in[i]=1: locked <= 0.
- Locked: grant goes only to the lock index. If that requester deasserts valid mid-packet, no other requester is granted and the channel idles.
- Latency: a beat accepted in cycle t is presented at t+1 when the stage was empty or popped in t. Sustained throughput is 1 beat/cycle with ready_out=1.
- Pop = valid_out & ready_out. Push and pop in the same cycle keep occupancy unchanged and preserve order.
- Backpressure: with ready_out=0, at most 2 beats are accepted, then all ready_in are 0. There is no loss, duplication or reordering.
- valid_out is set only by occupancy. data_out, last_out and sel_out stay stable while valid_out=1 and ready_out=0.
- NUM_REQS=1: arbitration is bypassed, ready_in[0] = space, sel_out=0. Lock tracking still drives locked.
- Reset mid-operation: buffered beats are discarded, lock is cleared, ptr returns to NUM_REQS-1. Requesters must restart their packets.
- Inputs that are invalid while not granted are ignored. valid_in may drop without a handshake, but a requester must not change data_in while valid_in=1 and ready_in=0.

Optional Feature:
- Macro: VX_ELASTIC_ARBITER_PERF_EN.
- With the macro defined, extra output perf_stalls [31:0] counts cycles with valid_out=1 and ready_out=0.
  - The counter saturates at 0xFFFFFFFF.
  - It is cleared asynchronously by reset.
- With the macro undefined, the perf_stalls port and its counter are absent and behaviour is otherwise identical.

Test Plan:
- Round-robin: NUM_REQS=4, all valid_in=1, last_in=1, ready_out=1. Grants go 0,1,2,3,0,1 on consecutive cycles; sel_out shows the same sequence delayed by 1 cycle; 1 beat/cycle; locked stays 0.
- Packet lock: requester 1 sends a 3-beat packet (last on beat 3) while requester 2 is valid throughout.
  - Output sel_out sequence is 1,1,1,2.
  - Insert a 2-cycle valid gap on requester 1 after beat 1: no beat from 2 appears, and locked=1 until beat 3 transfers.
- Backpressure: ready_out=0 for 5 cycles with all requesters valid. Exactly 2 beats are accepted and all ready_in=0 from then on. After ready_out=1, the beats emerge in grant order with data intact and no duplicates.
- Mid-packet reset: pull reset low during beat 2 of a packet from requester 3. valid_out and locked go 0 asynchronously. After release with all requesters valid, the first grant goes to requester 0.
- Degenerate: NUM_REQS=1. A stream of 8 beats with random ready_out shows data_out order preserved, sel_out=0, and last_out mirroring last_in.
- Perf (macro defined): 7 stall cycles interleaved with transfers give perf_stalls=7. Preload the counter near max to confirm it saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/vx_elastic_arbiter_if.sv
// Handshake bundle for vx_elastic_arbiter: NUM_REQS requester lanes on the
// input side, one elastic channel plus status on the output side.
interface vx_elastic_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int SEL_W    = 2
);
  logic [NUM_REQS-1:0]       valid_in;
  logic [NUM_REQS-1:0]       ready_in;
  logic [NUM_REQS*DATAW-1:0] data_in;
  logic [NUM_REQS-1:0]       last_in;
  logic                      valid_out;
  logic                      ready_out;
  logic [DATAW-1:0]          data_out;
  logic                      last_out;
  logic [SEL_W-1:0]          sel_out;
  logic                      locked;

  // Producer/consumer side that talks to the arbiter
  modport master (
    output valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, last_out, sel_out, locked
  );

  // Arbiter side
  modport slave (
    input  valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, last_out, sel_out, locked
  );
endinterface

// File: rtl/vx_elastic_arbiter.sv
// vx_elastic_arbiter: round-robin arbiter with packet lock feeding a 2-entry
// skid stage. Optional stall counter enabled by VX_ELASTIC_ARBITER_PERF_EN.
module vx_elastic_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int SEL_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_elastic_arbiter_if.slave   bus
`ifdef VX_ELASTIC_ARBITER_PERF_EN
  ,
  output logic [31:0]           perf_stalls
`endif
);

  typedef enum logic {S_OPEN, S_LOCKED} lock_state_e;

  lock_state_e         state_q, state_n;
  logic [SEL_W-1:0]    ptr_q, lock_idx_q;
  logic [NUM_REQS-1:0] grant, ready_v;
  logic [SEL_W-1:0]    gidx, cand;
  logic                found;
  int                  idx;
  logic                space, xfer, pop, push_last;
  logic [DATAW-1:0]    push_data;
  logic                ld_head_in, ld_head_tail, ld_tail_in;

  // Skid entries: _p0 is the head driving the outputs, _p1 the overflow slot
  logic                vld_p0, vld_p1;
  logic [DATAW-1:0]    data_p0, data_p1;
  logic                last_p0, last_p1;
  logic [SEL_W-1:0]    sel_p0, sel_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign space = ~vld_p1;

  // Grant selection: held to the lock owner mid-packet, otherwise rotate from ptr+1
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    if (NUM_REQS == 1) begin
      grant[0] = bus.valid_in[0];
    end else if (state_q == S_LOCKED) begin
      grant[lock_idx_q] = bus.valid_in[lock_idx_q];
      gidx              = lock_idx_q;
    end else begin
      for (int k = 1; k <= NUM_REQS; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQS) idx = idx - NUM_REQS;
        cand = SEL_W'(idx);
        if (!found && bus.valid_in[cand]) begin
          grant[cand] = 1'b1;
          gidx        = cand;
          found       = 1'b1;
        end
      end
    end
  end

  // Handshake decode and skid-stage load steering
  always_comb begin
    ready_v      = (NUM_REQS == 1) ? {NUM_REQS{space}} : (grant & {NUM_REQS{space}});
    xfer         = |(bus.valid_in & ready_v);
    push_data    = bus.data_in[int'(gidx)*DATAW +: DATAW];
    push_last    = bus.last_in[gidx];
    pop          = vld_p0 & bus.ready_out;
    ld_head_tail = pop & vld_p1;
    ld_head_in   = xfer & (~vld_p0 | (pop & ~vld_p1));
    ld_tail_in   = xfer & vld_p0 & (pop == vld_p1);
  end

  // Lock FSM next state: a non-last beat opens a packet, a last beat closes it
  always_comb begin
    state_n = state_q;
    if (xfer) state_n = push_last ? S_OPEN : S_LOCKED;
  end

  // Control state: lock, round-robin pointer, skid occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_OPEN;
      ptr_q      <= SEL_W'(NUM_REQS - 1);
      lock_idx_q <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      state_q <= state_n;
      if (xfer) ptr_q <= gidx;
      if (xfer && !push_last) lock_idx_q <= gidx;
      vld_p0 <= vld_p0 ? ~(pop & ~vld_p1 & ~xfer) : xfer;
      vld_p1 <= vld_p1 ? ~(pop & ~xfer) : (xfer & vld_p0 & ~pop);
    end
  end

  // Skid payload: head refills from the tail or the winner, tail takes overflow
  always_ff @(posedge clk) begin
    if (ld_head_tail) begin
      data_p0 <= data_p1;
      last_p0 <= last_p1;
      sel_p0  <= sel_p1;
    end else if (ld_head_in) begin
      data_p0 <= push_data;
      last_p0 <= push_last;
      sel_p0  <= gidx;
    end
    if (ld_tail_in) begin
      data_p1 <= push_data;
      last_p1 <= push_last;
      sel_p1  <= gidx;
    end
  end

  assign bus.ready_in  = ready_v;
  assign bus.valid_out = vld_p0;
  assign bus.data_out  = vld_p0 ? data_p0 : '0;
  assign bus.last_out  = vld_p0 & last_p0;
  assign bus.sel_out   = vld_p0 ? sel_p0 : '0;
  assign bus.locked    = (state_q == S_LOCKED);

`ifdef VX_ELASTIC_ARBITER_PERF_EN
  logic [31:0] perf_q;

  // Count cycles where the head beat is held by downstream backpressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else if (vld_p0 && !bus.ready_out) perf_q <= sat_inc(perf_q);
  end

  assign perf_stalls = perf_q;
`endif

endmodule

// File: tb/tb_vx_elastic_arbiter.sv
// Directed bench for vx_elastic_arbiter: 4-requester table plus hand-written
// reset, single-requester and (with VX_ELASTIC_ARBITER_PERF_EN) stall-counter sequences.
module tb_vx_elastic_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vx_elastic_arbiter_if #(.NUM_REQS(4), .DATAW(32), .SEL_W(2)) bus4 ();
  vx_elastic_arbiter_if #(.NUM_REQS(1), .DATAW(32), .SEL_W(1)) bus1 ();

`ifdef VX_ELASTIC_ARBITER_PERF_EN
  logic [31:0] perf4, perf1;
`endif

  vx_elastic_arbiter #(.NUM_REQS(4), .DATAW(32), .SEL_W(2)) u4 (
    .clk(clk), .reset(reset), .bus(bus4)
`ifdef VX_ELASTIC_ARBITER_PERF_EN
    , .perf_stalls(perf4)
`endif
  );

  vx_elastic_arbiter #(.NUM_REQS(1), .DATAW(32), .SEL_W(1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef VX_ELASTIC_ARBITER_PERF_EN
    , .perf_stalls(perf1)
`endif
  );

  typedef struct packed {
    logic [3:0] vin;
    logic [3:0] lin;
    logic       rdy;
    logic [3:0] exp_rin;
    logic       exp_vout;
    logic [1:0] exp_sel;
    logic       exp_lock;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] d1(input int k);
    return 32'h5EED_0000 + k;
  endfunction

  function automatic logic l1(input int k);
    return (k % 3 == 2) || (k == 7);
  endfunction

`ifdef VX_ELASTIC_ARBITER_PERF_EN
  task automatic pcyc(input logic [3:0] vin, input logic rdy);
    @(negedge clk);
    bus4.valid_in  = vin;
    bus4.last_in   = 4'hF;
    bus4.ready_out = rdy;
  endtask
`endif

  initial begin
    bus4.valid_in  = '0;
    bus4.last_in   = '0;
    bus4.ready_out = 1'b0;
    for (int i = 0; i < 4; i++) bus4.data_in[i*32 +: 32] = 32'hA5A5_0000 + i;
    bus1.valid_in  = '0;
    bus1.last_in   = '0;
    bus1.ready_out = 1'b0;
    bus1.data_in   = '0;

    //          vin    lin    rdy   rin    vout  sel   lock
    // round-robin, all valid, single-beat packets
    vecs[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 1'b0};
    vecs[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 1'b0};
    vecs[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 1'b0};
    vecs[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 1'b0};
    vecs[5]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 1'b0};
    vecs[6]  = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 1'b0};
    // single beat from 0 so requester 1 is next in line
    vecs[7]  = '{4'h1, 4'h1, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0};
    // 3-beat packet on 1 with a 2-cycle gap, requester 2 waiting
    vecs[8]  = '{4'h6, 4'h4, 1'b1, 4'h2, 1'b1, 2'd0, 1'b0};
    vecs[9]  = '{4'h4, 4'h4, 1'b1, 4'h0, 1'b1, 2'd1, 1'b1};
    vecs[10] = '{4'h4, 4'h4, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1};
    vecs[11] = '{4'h6, 4'h4, 1'b1, 4'h2, 1'b0, 2'd0, 1'b1};
    vecs[12] = '{4'h6, 4'h6, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1};
    vecs[13] = '{4'h4, 4'h4, 1'b1, 4'h4, 1'b1, 2'd1, 1'b0};
    vecs[14] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 1'b0};
    vecs[15] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
    // backpressure: 5 cycles of ready_out=0 with everyone valid
    vecs[16] = '{4'hF, 4'hF, 1'b0, 4'h8, 1'b0, 2'd0, 1'b0};
    vecs[17] = '{4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 2'd3, 1'b0};
    vecs[18] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b0};
    vecs[19] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b0};
    vecs[20] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b0};
    vecs[21] = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 1'b0};
    vecs[22] = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 1'b0};
    vecs[23] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 1'b0};
    vecs[24] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};

    // reset state
    #12;
    chk("rst_vout", 32'(bus4.valid_out), 32'd0);
    chk("rst_lock", 32'(bus4.locked), 32'd0);
    chk("rst_data", bus4.data_out, 32'd0);
    chk("rst_sel",  32'(bus4.sel_out), 32'd0);
    chk("rst_last", 32'(bus4.last_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 25; v++) begin
      @(negedge clk);
      bus4.valid_in  = vecs[v].vin;
      bus4.last_in   = vecs[v].lin;
      bus4.ready_out = vecs[v].rdy;
      #1;
      chk($sformatf("v%0d_rin", v),  32'(bus4.ready_in),  32'(vecs[v].exp_rin));
      chk($sformatf("v%0d_vout", v), 32'(bus4.valid_out), 32'(vecs[v].exp_vout));
      chk($sformatf("v%0d_sel", v),  32'(bus4.sel_out),   32'(vecs[v].exp_sel));
      chk($sformatf("v%0d_lock", v), 32'(bus4.locked),    32'(vecs[v].exp_lock));
      chk($sformatf("v%0d_data", v), bus4.data_out,
          vecs[v].exp_vout ? 32'hA5A5_0000 + 32'(vecs[v].exp_sel) : 32'd0);
    end

    // mid-packet reset on requester 3
    @(negedge clk);
    bus4.valid_in  = 4'h8;
    bus4.last_in   = 4'h0;
    bus4.ready_out = 1'b1;
    #1 chk("mr_rin_b1", 32'(bus4.ready_in), 32'h8);
    @(negedge clk);
    #1;
    chk("mr_rin_b2", 32'(bus4.ready_in), 32'h8);
    chk("mr_sel_b1", 32'(bus4.sel_out), 32'd3);
    chk("mr_lock_b2", 32'(bus4.locked), 32'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mr_vout_async", 32'(bus4.valid_out), 32'd0);
    chk("mr_lock_async", 32'(bus4.locked), 32'd0);
    @(negedge clk);
    bus4.valid_in = 4'hF;
    bus4.last_in  = 4'hF;
    reset = 1'b1;
    #1 chk("mr_first_grant", 32'(bus4.ready_in), 32'h1);
    @(negedge clk);
    #1;
    chk("mr_first_sel", 32'(bus4.sel_out), 32'd0);
    chk("mr_first_vout", 32'(bus4.valid_out), 32'd1);
    bus4.valid_in = 4'h0;
    @(negedge clk);
    @(negedge clk);

    // single requester stream with random backpressure
    begin
      int tx = 0;
      int rx = 0;
      int cyc = 0;
      logic acc;
      while (rx < 8 && cyc < 200) begin
        @(negedge clk);
        bus1.valid_in  = (tx < 8) ? 1'b1 : 1'b0;
        bus1.data_in   = d1(tx);
        bus1.last_in   = l1(tx);
        bus1.ready_out = 1'($urandom_range(0, 1));
        #1;
        acc = bus1.valid_in[0] & bus1.ready_in[0];
        if (bus1.valid_out && bus1.ready_out) begin
          chk($sformatf("n1_data%0d", rx), bus1.data_out, d1(rx));
          chk($sformatf("n1_last%0d", rx), 32'(bus1.last_out), 32'(l1(rx)));
          chk($sformatf("n1_sel%0d", rx), 32'(bus1.sel_out), 32'd0);
          rx++;
        end
        @(posedge clk);
        if (acc) tx++;
        cyc++;
      end
      chk("n1_count", 32'(rx), 32'd8);
      @(negedge clk);
      bus1.valid_in  = 1'b0;
      bus1.ready_out = 1'b1;
      #1;
      chk("n1_lock_end", 32'(bus1.locked), 32'd0);
      chk("n1_empty", 32'(bus1.valid_out), 32'd0);
    end

`ifdef VX_ELASTIC_ARBITER_PERF_EN
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("perf_rst", perf4, 32'd0);
    pcyc(4'h1, 1'b1);
    repeat (3) pcyc(4'h0, 1'b0);
    pcyc(4'h0, 1'b1);
    pcyc(4'h1, 1'b1);
    repeat (4) pcyc(4'h0, 1'b0);
    pcyc(4'h0, 1'b1);
    @(negedge clk);
    #1 chk("perf_seven", perf4, 32'd7);
    force u4.perf_q = 32'hFFFF_FFFE;
    #1 release u4.perf_q;
    pcyc(4'h1, 1'b1);
    repeat (3) pcyc(4'h0, 1'b0);
    pcyc(4'h0, 1'b1);
    @(negedge clk);
    #1 chk("perf_sat", perf4, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
